// File: rtl/matched_readout.sv
// -----------------------------------------------------------------------------
// matched_readout
//
// Read side of the four matched-result SRAM banks. Once the match engine has
// finished, a start pulse drains group_count addresses. Each address is read
// from all four banks at once through the shared addr2 port. The four words
// are captured and then presented one per slot on a valid/ready stream, in the
// order bank 0, 1, 2, 3.
//
// Configuration macro: SKIP_INVALID_EN
//   When defined, a slot whose record-valid flag (bit DATA_W-1) is 0 is not
//   presented. It is consumed in one cycle and is not counted.
//   When undefined, every slot is presented.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start             begin a drain (sampled only in IDLE)
//   group_count       number of addresses to drain, clamped to 512
//   mem_addr          shared read address to all four banks (0 outside RD/CAP)
//   mem_dout_0..3     bank read data, valid one cycle after mem_addr
//   out_valid/ready   record stream handshake
//   out_data          record
//   out_bank          source bank of the record
//   out_addr          source address of the record
//   busy              high from start acceptance until done
//   done              one-cycle pulse at the end of a drain
//   out_count         records accepted this drain; held until the next start
//   dbg_state         current FSM state, for checkers
//
// Handshake: a record transfers on a rising edge where out_valid && out_ready.
// out_valid depends only on registered state. It never depends on out_ready.
// While out_valid is high and out_ready is low, out_data, out_bank and
// out_addr hold stable.
// -----------------------------------------------------------------------------
module matched_readout #(
    parameter int DATA_W = 47,
    parameter int ADDR_W = 9,
    parameter int NBANK  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [9:0]        group_count,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_dout_0,
    input  logic [DATA_W-1:0] mem_dout_1,
    input  logic [DATA_W-1:0] mem_dout_2,
    input  logic [DATA_W-1:0] mem_dout_3,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_bank,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done,
    output logic [11:0]       out_count,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CAP  = 3'd2,
        S_EMIT = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [9:0]        cnt;
    logic [1:0]        slot;
    logic [DATA_W-1:0] hold [NBANK];

    logic [9:0] gc_clamped;
    logic       slot_ok;
    logic       accept;
    logic       advance;
    logic       last_addr;

    assign gc_clamped = (group_count > 10'd512) ? 10'd512 : group_count;

    // Compare on 10 bits so that a count of 512 ends at address 511.
    assign last_addr = ({1'b0, addr} == (cnt - 10'd1));

`ifdef SKIP_INVALID_EN
    assign slot_ok = hold[slot][DATA_W-1];
`else
    assign slot_ok = 1'b1;
`endif

    assign out_valid = (state == S_EMIT) && slot_ok;
    assign out_data  = (state == S_EMIT) ? hold[slot] : '0;
    assign out_bank  = (state == S_EMIT) ? slot : 2'd0;
    assign out_addr  = (state == S_EMIT) ? addr : '0;
    assign accept    = out_valid && out_ready;
    // A skipped slot (slot_ok == 0) is consumed without waiting on the sink.
    assign advance   = (state == S_EMIT) && (accept || !slot_ok);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            addr      <= '0;
            cnt       <= '0;
            slot      <= '0;
            mem_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_count <= '0;
            for (int i = 0; i < NBANK; i++) hold[i] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt       <= gc_clamped;
                        out_count <= '0;
                        addr      <= '0;
                        mem_addr  <= '0;
                        if (gc_clamped != 10'd0) begin
                            busy  <= 1'b1;
                            state <= S_RD;
                        end else begin
                            done  <= 1'b1;
                            state <= S_FIN;
                        end
                    end
                end
                // mem_addr already carries addr. The banks register their
                // data on the edge that leaves this state.
                S_RD: state <= S_CAP;
                S_CAP: begin
                    hold[0]  <= mem_dout_0;
                    hold[1]  <= mem_dout_1;
                    hold[2]  <= mem_dout_2;
                    hold[3]  <= mem_dout_3;
                    slot     <= 2'd0;
                    mem_addr <= '0;
                    state    <= S_EMIT;
                end
                S_EMIT: begin
                    if (accept) out_count <= out_count + 12'd1;
                    if (advance) begin
                        if (slot == 2'd3) begin
                            if (last_addr) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= S_FIN;
                            end else begin
                                addr     <= addr + 1'b1;
                                mem_addr <= addr + 1'b1;
                                state    <= S_RD;
                            end
                        end else begin
                            slot <= slot + 2'd1;
                        end
                    end
                end
                // A start pulse arriving in this cycle is ignored.
                S_FIN:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matched_readout.sv
// -----------------------------------------------------------------------------
// tb_matched_readout
//
// Checks matched_readout against a reference model. The model lists the
// records a drain must produce: every address, every bank, optionally
// dropping records whose flag bit is clear. The bench compares every accepted
// record, the hold-while-stalled behaviour, latency, done, busy and out_count.
// -----------------------------------------------------------------------------
module tb_matched_readout;

    localparam int DATA_W = 47;
    localparam int ADDR_W = 9;
    localparam int REC_W  = ADDR_W + 2 + DATA_W;

`ifdef SKIP_INVALID_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              start = 1'b0;
    logic [9:0]        group_count = '0;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_dout_0, mem_dout_1, mem_dout_2, mem_dout_3;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_bank;
    logic [ADDR_W-1:0] out_addr;
    logic              busy, done;
    logic [11:0]       out_count;
    logic [2:0]        dbg_state;

    matched_readout dut (
        .clk(clk), .rst(rst), .start(start), .group_count(group_count),
        .mem_addr(mem_addr),
        .mem_dout_0(mem_dout_0), .mem_dout_1(mem_dout_1),
        .mem_dout_2(mem_dout_2), .mem_dout_3(mem_dout_3),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_bank(out_bank), .out_addr(out_addr), .busy(busy), .done(done),
        .out_count(out_count), .dbg_state(dbg_state)
    );

    // ---------------- memory model: registered read ----------------
    logic [DATA_W-1:0] mem [4][512];
    always @(posedge clk) begin
        mem_dout_0 <= mem[0][mem_addr];
        mem_dout_1 <= mem[1][mem_addr];
        mem_dout_2 <= mem[2][mem_addr];
        mem_dout_3 <= mem[3][mem_addr];
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- sink ready driver ----------------
    int ready_mode = 0;   // 0: always 1, 1: toggle, 2: random
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       out_ready = ~out_ready;
                2:       out_ready = ($urandom_range(0, 2) != 0);
                default: out_ready = 1'b1;
            endcase
        end
    end

    // ---------------- scoreboard / monitor ----------------
    logic [REC_W-1:0] exp_q[$];
    int               hs_cnt = 0;
    int               done_cnt = 0;
    logic             pv = 1'b0, pr = 1'b0;
    logic [REC_W-1:0] prec = '0;

    always @(negedge clk) begin
        logic [REC_W-1:0] rec;
        rec = {out_addr, out_bank, out_data};
        if (rst) begin
            pv = 1'b0;
            pr = 1'b0;
        end else begin
            if (pv && !pr) begin
                check("stall_valid", out_valid, 1);
                check("stall_hold", rec, prec);
            end
            if (out_valid && out_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) check("extra_rec", exp_q.size(), 1);
                else check("rec", rec, exp_q.pop_front());
            end
            if (done) done_cnt++;
            pv   = out_valid;
            pr   = out_ready;
            prec = rec;
        end
    end

    // ---------------- stimulus helpers ----------------
    // fill_mode 0: all valid; 1: bank 2 invalid everywhere; 2: random flags
    task automatic fill_mem(input int fill_mode);
        for (int b = 0; b < 4; b++)
            for (int a = 0; a < 512; a++) begin
                logic [DATA_W-1:0] w;
                w = {$urandom, $urandom};
                case (fill_mode)
                    1:       w[DATA_W-1] = (b != 2);
                    2:       w[DATA_W-1] = $urandom_range(0, 1);
                    default: w[DATA_W-1] = 1'b1;
                endcase
                mem[b][a] = w;
            end
    endtask

    int exp_n = 0;

    task automatic start_drain(input int gc, input bit check_lat);
        int n;
        n = (gc > 512) ? 512 : gc;
        exp_q.delete();
        for (int a = 0; a < n; a++)
            for (int b = 0; b < 4; b++)
                if (!SKIP || mem[b][a][DATA_W-1]) begin
                    logic [ADDR_W-1:0] aa;
                    logic [1:0]        bb;
                    aa = a[ADDR_W-1:0];
                    bb = b[1:0];
                    exp_q.push_back({aa, bb, mem[b][a]});
                end
        exp_n    = exp_q.size();
        hs_cnt   = 0;
        done_cnt = 0;
        @(posedge clk);
        #1;
        start       = 1'b1;
        group_count = gc[9:0];
        @(posedge clk);
        #1;
        start = 1'b0;
        if (check_lat) begin
            if (n == 0) begin
                check("zero_done", done, 1);
            end else begin
                check("lat_busy", busy, 1);
                check("lat_e1", out_valid, 0);
                @(posedge clk);
                #1;
                check("lat_e2", out_valid, 0);
                @(posedge clk);
                #1;
                check("lat_e3", out_valid, 1);
            end
        end
    endtask

    task automatic finish_drain(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, seen, 1);
        check({tag, "_busy_fin"}, busy, 0);
        check({tag, "_count"}, out_count, exp_n);
        repeat (3) @(negedge clk);
        check({tag, "_q_empty"}, exp_q.size(), 0);
        check({tag, "_hs"}, hs_cnt, exp_n);
        check({tag, "_one_done"}, done_cnt, 1);
        check({tag, "_count_held"}, out_count, exp_n);
        check({tag, "_addr_idle"}, mem_addr, 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        fill_mem(0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count", out_count, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_data", {out_addr, out_bank, out_data}, 0);
        rst = 1'b0;

        // T1: two groups, sink always ready, latency checked
        ready_mode = 0;
        start_drain(2, 1'b1);
        finish_drain("t1");
        check("t1_count8", out_count, 8);

        // T2: one group, sink toggles every cycle
        ready_mode = 1;
        fill_mem(0);
        start_drain(1, 1'b0);
        finish_drain("t2");
        check("t2_count4", out_count, 4);

        // T3: zero groups
        ready_mode = 0;
        start_drain(0, 1'b1);
        finish_drain("t3");

        // T4: bank 2 flagged invalid everywhere
        fill_mem(1);
        start_drain(3, 1'b0);
        finish_drain("t4");
        check("t4_count", out_count, SKIP ? 9 : 12);

        // T5: reset in the middle of address 1
        begin
            bit found;
            found = 1'b0;
            fill_mem(0);
            ready_mode = 2;
            start_drain(3, 1'b0);
            for (int i = 0; i < 200; i++) begin
                @(posedge clk);
                #1;
                if (out_valid && out_addr == 9'd1) begin
                    found = 1'b1;
                    break;
                end
            end
            check("t5_reached_a1", found, 1);
            rst = 1'b1;
            @(posedge clk);
            #1;
            check("t5_valid", out_valid, 0);
            check("t5_busy", busy, 0);
            check("t5_done", done, 0);
            check("t5_count", out_count, 0);
            rst = 1'b0;
            exp_q.delete();
            done_cnt = 0;
            repeat (4) @(negedge clk);
            check("t5_no_done", done_cnt, 0);
            ready_mode = 0;
            start_drain(1, 1'b0);
            finish_drain("t5b");
        end

        // T6: second start while busy is ignored
        fill_mem(0);
        start_drain(2, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        start       = 1'b1;
        group_count = 10'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        finish_drain("t6");

        // Clamp: a count above 512 drains all 512 groups
        fill_mem(0);
        start_drain(700, 1'b0);
        finish_drain("clamp");
        check("clamp_2048", out_count, 2048);

        // Random drains with random flags and random back-pressure
        for (int r = 0; r < 4; r++) begin
            fill_mem(2);
            ready_mode = 2;
            start_drain($urandom_range(1, 6), 1'b0);
            finish_drain("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
